morse_key_sequencer: RTL and testbench

Front-end controller that sequences the character shift/display register of the Morse decoder. It times a single debounced Morse key against a 1 kHz tick and classifies each press as dot or dash. It accumulates up to four elements per letter and commits a letter on button or inter-letter gap. It drives the register's `flag`, `backspace_button` and `keyboard_val` inputs with single-cycle, well-ordered pulses.

---
 rtl/morse_key_sequencer.sv | 135 +++++++++++++
 tb/tb_morse_key_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/morse_key_sequencer.sv
// Times a debounced Morse key against a 1 kHz tick, builds up to four dot/dash elements
// and commits letters to the shift register. Define MORSE_AUTOCOMMIT_EN for gap auto-commit.
module morse_key_sequencer #(
    parameter int MIN_TICKS  = 10,
    parameter int DASH_TICKS = 200,
    parameter int GAP_TICKS  = 600,
    parameter int CNT_W      = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       tick,
    input  logic       key,
    input  logic       commit_btn,
    input  logic       bksp_btn,
    output logic [3:0] keyboard_val,
    output logic [2:0] elem_len,
    output logic       flag,
    output logic       backspace_button,
    output logic       err
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRESS  = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             ovf, ovf_nx;
    logic [3:0]       kv_nx;
    logic [2:0]       len_nx;
    logic             flag_nx, bksp_nx, err_nx;
    logic             auto_en, gap_done;
    logic [1:0]       last_idx;

`ifdef MORSE_AUTOCOMMIT_EN
    assign auto_en = 1'b1;
`else
    assign auto_en = 1'b0;
`endif

    assign gap_done = auto_en && (cnt >= GAP_C);
    assign last_idx = 2'(elem_len - 3'd1);

    always_comb begin
        state_nx = state;
        kv_nx    = keyboard_val;
        len_nx   = elem_len;
        ovf_nx   = ovf;
        flag_nx  = 1'b0;
        bksp_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            S_IDLE, S_GAP: begin
                // key beats everything, then backspace, then commit/timeout
                if (key) begin
                    state_nx = S_PRESS;
                end else if (bksp_btn) begin
                    if (elem_len != 3'd0) begin
                        len_nx           = elem_len - 3'd1;
                        kv_nx[last_idx]  = 1'b0;
                        ovf_nx           = 1'b0;
                        if (elem_len == 3'd1) state_nx = S_IDLE;
                    end else begin
                        bksp_nx = 1'b1;
                    end
                end else if (state == S_GAP && (commit_btn || gap_done)) begin
                    state_nx = S_COMMIT;
                    flag_nx  = !ovf;
                    err_nx   = ovf;
                end
            end
            S_PRESS: begin
                if (!key) begin
                    if (cnt < MIN_C) begin
                        state_nx = (elem_len != 3'd0) ? S_GAP : S_IDLE;
                    end else begin
                        state_nx = S_GAP;
                        if (elem_len == 3'd4) begin
                            ovf_nx = 1'b1;
                        end else begin
                            kv_nx[elem_len[1:0]] = (cnt >= DASH_C);
                            len_nx               = elem_len + 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                kv_nx    = 4'd0;
                len_nx   = 3'd0;
                ovf_nx   = 1'b0;
            end
        endcase
        if (!en) begin
            state_nx = S_IDLE;
            kv_nx    = 4'd0;
            len_nx   = 3'd0;
            ovf_nx   = 1'b0;
            flag_nx  = 1'b0;
            bksp_nx  = 1'b0;
            err_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ovf              <= 1'b0;
            keyboard_val     <= 4'd0;
            elem_len         <= 3'd0;
            flag             <= 1'b0;
            backspace_button <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= state_nx;
            ovf              <= ovf_nx;
            keyboard_val     <= kv_nx;
            elem_len         <= len_nx;
            flag             <= flag_nx;
            backspace_button <= bksp_nx;
            err              <= err_nx;
            // counter restarts on every state entry and saturates otherwise
            if (state_nx != state)
                cnt <= '0;
            else if (tick && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboard bench: expected strobe packets are queued when stimulus is driven and
// popped by a monitor whenever flag, err or backspace_button fires.
module tb_morse_key_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, en, tick, key, commit_btn, bksp_btn;
    logic [3:0] keyboard_val;
    logic [2:0] elem_len;
    logic       flag, backspace_button, err;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb_q[$];

    morse_key_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .key(key),
        .commit_btn(commit_btn), .bksp_btn(bksp_btn),
        .keyboard_val(keyboard_val), .elem_len(elem_len), .flag(flag),
        .backspace_button(backspace_button), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(logic f, logic b, logic e, logic [3:0] kv, logic [2:0] len);
        return {f, b, e, kv, len};
    endfunction

    function automatic logic [9:0] pkt();
        return {flag, backspace_button, err, keyboard_val, elem_len};
    endfunction

    // every strobe cycle must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (flag || backspace_button || err)) begin
            if (sb_q.size() == 0) chk("unexpected_strobe", 32'(pkt()), 32'd0);
            else chk("strobe", 32'(pkt()), 32'(sb_q.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    task automatic press(input int n);
        key = 1'b1; cyc(2);
        ticks(n);
        key = 1'b0; cyc(1);
    endtask

    task automatic pulse_commit();
        commit_btn = 1'b1; cyc(1);
        commit_btn = 1'b0;
    endtask

    task automatic pulse_bksp();
        bksp_btn = 1'b1; cyc(1);
        bksp_btn = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; tick = 1'b0; key = 1'b0;
        commit_btn = 1'b0; bksp_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(pkt()), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // letter A: dot, dash
        press(50); ticks(20); press(300);
        chk("a_len", 32'(elem_len), 32'd2);
        chk("a_kv", 32'(keyboard_val), 32'b0010);
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0010, 3'd2));
        pulse_commit();
        chk("a_flag_latency", 32'(flag), 32'd1);
        cyc(1);
        chk("a_flag_one_cycle", 32'(flag), 32'd0);
        chk("a_cleared", 32'({keyboard_val, elem_len}), 32'd0);

        // long release after one dot
        press(50);
`ifdef MORSE_AUTOCOMMIT_EN
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 3'd1));
        ticks(600);
        chk("auto_flag", 32'(flag), 32'd1);
        cyc(2);
        chk("auto_cleared", 32'(elem_len), 32'd0);
`else
        ticks(600);
        cyc(2);
        chk("noauto_pending", 32'(elem_len), 32'd1);
        pulse_bksp();
        chk("noauto_bksp_clear", 32'(elem_len), 32'd0);
`endif

        // classification boundaries
        press(9);
        chk("glitch9_len", 32'(elem_len), 32'd0);
        press(10);
        chk("p10_dot", 32'({keyboard_val, elem_len}), 32'({4'b0000, 3'd1}));
        press(199);
        chk("p199_dot", 32'({keyboard_val, elem_len}), 32'({4'b0000, 3'd2}));
        press(200);
        chk("p200_dash", 32'({keyboard_val, elem_len}), 32'({4'b0100, 3'd3}));
        press(9);
        chk("glitch9_gap", 32'({keyboard_val, elem_len}), 32'({4'b0100, 3'd3}));
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0100, 3'd3));
        pulse_commit();
        cyc(2);

        // overflow: five dots
        repeat (5) press(20);
        chk("ovf_len_held", 32'(elem_len), 32'd4);
        sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 3'd4));
        pulse_commit();
        chk("ovf_err", 32'({flag, err}), 32'b01);
        cyc(1);
        chk("ovf_cleared", 32'(elem_len), 32'd0);

        // backspace on dash, dot
        press(250); press(20);
        chk("bs_pre", 32'({keyboard_val, elem_len}), 32'({4'b0000, 3'd2} | {4'b0001, 3'd0}));
        pulse_bksp();
        chk("bs_one", 32'({keyboard_val, elem_len}), 32'({4'b0001, 3'd1}));
        pulse_bksp();
        chk("bs_empty", 32'({keyboard_val, elem_len}), 32'd0);
        sb_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 3'd0));
        pulse_bksp();
        chk("bs_strobe", 32'(backspace_button), 32'd1);
        cyc(1);
        chk("bs_strobe_one_cycle", 32'(backspace_button), 32'd0);

        // backspace and commit together
        press(20);
        bksp_btn = 1'b1; commit_btn = 1'b1; cyc(1);
        bksp_btn = 1'b0; commit_btn = 1'b0;
        chk("bs_commit_noflag", 32'({flag, elem_len}), 32'd0);
        cyc(2);

        // enable drop in GAP
        press(20);
        en = 1'b0; cyc(1);
        chk("en_abort", 32'(pkt()), 32'd0);
        en = 1'b1;
        pulse_commit();
        cyc(2);
        chk("en_commit_ignored", 32'(elem_len), 32'd0);

        // reset mid-press with a pending element
        press(20);
        key = 1'b1; cyc(2); ticks(30);
        rst_n = 1'b0; #1;
        chk("rst_mid_press", 32'(pkt()), 32'd0);
        key = 1'b0; cyc(1);
        rst_n = 1'b1; cyc(3);
        chk("rst_after_release", 32'(elem_len), 32'd0);

        cyc(5);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
